select_encode_seq: RTL and testbench
====================================

Name: select_encode_seq

Overview:
- Parameterised successor to the register select/encode unit of the Mini SRC datapath.
- Holds a local copy of the IR and decodes the Ra/Rb/Rc fields to one-hot register in/out enables for REG_COUNT registers.
- Two modes: direct, where the control unit drives Gra/Grb/Grc strobes, and auto-sequenced, where one start pulse walks the selected fields, one register per clock.
- Also forces R0-reads-as-zero under BAout, produces the sign-extended C constant, and flags control conflicts.

Parameters:
- REG_COUNT, 16, register count; power of two, 16 or 32. SEL_W = log2(REG_COUNT).
- DATA_WIDTH, 32, IR and constant width.
- OPCODE_WIDTH, 5, opcode bits at IR MSBs.
- C_WIDTH, 19, width of C field at IR[C_WIDTH-1:0].

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous active-low reset
- IRin  in  1  load IR_Data into internal IR
- IR_Data  in  DATA_WIDTH  instruction from bus
- Gra, Grb, Grc  in  1 each  direct field select strobes
- Rin, Rout, BAout  in  1 each  direct direction strobes
- start  in  1  begin auto sequence (single-cycle pulse)
- seq_mask  in  3  fields to sequence {c,b,a}
- seq_dir  in  1  0 = drive RXout, 1 = drive RXin
- seq_ba  in  1  apply BAout semantics during sequence
- err_clr  in  1  clear sticky err
- RXin  out  REG_COUNT  one-hot register input enable
- RXout  out  REG_COUNT  one-hot register output enable
- C_sign_extended  out  DATA_WIDTH  sign-extended C field
- r0_zero  out  1  bus must read zero (BAout selected R0)
- busy  out  1  sequence in progress
- done  out  1  one-cycle sequence completion pulse
- err  out  1  sticky conflict flag

Behaviour:
- Fields are taken from the internal IR, never from IR_Data directly:
  - Ra = IR[DATA_WIDTH-OPCODE_WIDTH-1 -: SEL_W]
  - Rb = the next SEL_W bits below Ra
  - Rc = the next SEL_W bits below Rb
  - With defaults: Ra = [26:23], Rb = [22:19], Rc = [18:15].
- IR register: loads on the clock edge where IRin=1.
- C_sign_extended = IR[C_WIDTH-1:0] sign-extended by IR[C_WIDTH-1]. Combinational from IR.
- Reset (clear=0, asynchronous): IR=0, state IDLE, busy=0, done=0, err=0, latched mask/dir/ba=0.
  - RXin/RXout are 0 unless direct strobes are high; direct decode stays live during reset.
  - A reset mid-sequence aborts immediately and no done is issued.
- State machine: IDLE, ISSUE.
- IDLE, direct mode (combinational):
  - field = OR of the fields whose strobe is high.
  - One-hot decode of field; RXin = decode & Rin; RXout = decode & (Rout | BAout).
- IDLE, start=1 with seq_mask≠0:
  - Latch mask, dir and ba; go to ISSUE.
  - busy=1 from the next cycle.
- IDLE, start=1 with seq_mask=0: done=1 next cycle; busy and RX outputs stay 0.
- ISSUE:
  - Each cycle, issue the lowest remaining mask bit (order a, then b, then c) and clear that bit.
  - The issued field's one-hot decode drives RXout (dir=0) or RXin (dir=1). These are registered outputs.
  - When the last bit is issued: done=1 in that same cycle; next state IDLE; busy=0 in the following cycle.
- Latency: start at edge k gives the first issue in cycle k+1. N set bits take N cycles.
- start together with IRin on the same edge: the IR loads first, and the sequence uses the new IR.
- IRin while busy: the IR loads; remaining issues decode from the new IR (documented behaviour).
- BAout / seq_ba, when the selected field is 0:
  - The R0 bit of RXout is suppressed (RXout = 0) and r0_zero=1.
  - Nonzero fields behave as Rout.
  - Rin and RXin are unaffected.
- Conflicts, each of which sets err=1 (sticky):
  - start while busy: the start is ignored.
  - Any Gra/Grb/Grc strobe while busy: the strobe is ignored; sequence outputs take priority.
  - Direct mode with more than one G strobe high: the OR is still output.
- err_clr clears err. If err_clr and a new conflict occur in the same cycle, err stays 1.

Test Plan:
- Reset, then IRin with IR_Data=0x029E0000 (Ra=5, Rb=3, Rc=12) -> C_sign_extended=0xFFFE0000; all outputs 0 with strobes low.
- Direct Grb+Rout -> RXout=0x0008, RXin=0; then Grc+Rin -> RXin=0x1000.
- start, seq_mask=3'b111, seq_dir=0 -> RXout = 0x0020, 0x0008, 0x1000 on three consecutive cycles; done on the third; busy high those three cycles only.
- IR with Rb=0; Grb+BAout -> RXout=0, r0_zero=1. Same field with Rout only -> RXout=0x0001, r0_zero=0.
- start while busy, or Gra during a sequence -> sequence unchanged, err=1 and held; err_clr -> err=0. start with seq_mask=0 -> done one cycle later, no RX activity.
- Drop clear mid-sequence after the first issue -> outputs 0 immediately, no done. REG_COUNT=32 build: Ra=[26:22]=17 via Gra+Rin -> RXin=0x00020000.

Source files
------------

// File: rtl/select_encode_seq_if.sv
// Control/bus bundle for the register select/encode unit: control-unit strobes
// and IR input in one direction, decoded register enables and status in the other.
interface select_encode_seq_if #(
  parameter int REG_COUNT  = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  IRin;
  logic [DATA_WIDTH-1:0] IR_Data;
  logic                  Gra;
  logic                  Grb;
  logic                  Grc;
  logic                  Rin;
  logic                  Rout;
  logic                  BAout;
  logic                  start;
  logic [2:0]            seq_mask;
  logic                  seq_dir;
  logic                  seq_ba;
  logic                  err_clr;
  logic [REG_COUNT-1:0]  RXin;
  logic [REG_COUNT-1:0]  RXout;
  logic [DATA_WIDTH-1:0] C_sign_extended;
  logic                  r0_zero;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output IRin, IR_Data, Gra, Grb, Grc, Rin, Rout, BAout,
    output start, seq_mask, seq_dir, seq_ba, err_clr,
    input  RXin, RXout, C_sign_extended, r0_zero, busy, done, err
  );

  modport slave (
    input  IRin, IR_Data, Gra, Grb, Grc, Rin, Rout, BAout,
    input  start, seq_mask, seq_dir, seq_ba, err_clr,
    output RXin, RXout, C_sign_extended, r0_zero, busy, done, err
  );
endinterface

// File: rtl/select_encode_seq.sv
// Register select/encode unit: decodes Ra/Rb/Rc from a local IR copy into one-hot
// register enables, either from direct G strobes or an auto-sequenced field walk.
module select_encode_seq #(
  parameter int REG_COUNT    = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 5,
  parameter int C_WIDTH      = 19
) (
  input  logic               clock,
  input  logic               clear,
  select_encode_seq_if.slave bus
);
  localparam int SEL_W = $clog2(REG_COUNT);
  localparam int RA_HI = DATA_WIDTH - OPCODE_WIDTH - 1;
  localparam int RB_HI = RA_HI - SEL_W;
  localparam int RC_HI = RB_HI - SEL_W;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] ir_reg;
  logic [2:0]            mask_reg, mask_next;
  logic                  dir_reg, dir_next;
  logic                  ba_reg, ba_next;
  logic                  zdone_reg, zdone_next;
  logic                  err_reg, err_next;

  logic [SEL_W-1:0]      ra, rb, rc;
  logic [SEL_W-1:0]      direct_field, seq_field, sel_field;
  logic [REG_COUNT-1:0]  dec;
  logic [REG_COUNT-1:0]  rx_in, rx_out;
  logic                  g_any, g_multi, conflict, r0z, done_c;

  assign ra = ir_reg[RA_HI -: SEL_W];
  assign rb = ir_reg[RB_HI -: SEL_W];
  assign rc = ir_reg[RC_HI -: SEL_W];

  assign g_any        = bus.Gra | bus.Grb | bus.Grc;
  assign g_multi      = (bus.Gra & bus.Grb) | (bus.Gra & bus.Grc) | (bus.Grb & bus.Grc);
  assign direct_field = ({SEL_W{bus.Gra}} & ra) | ({SEL_W{bus.Grb}} & rb) | ({SEL_W{bus.Grc}} & rc);
  // Lowest pending mask bit wins: a, then b, then c.
  assign seq_field    = mask_reg[0] ? ra : (mask_reg[1] ? rb : rc);
  assign sel_field    = (state_reg == ISSUE) ? seq_field : direct_field;

  generate
    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_dec
      assign dec[gi] = (sel_field == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    mask_next  = mask_reg;
    dir_next   = dir_reg;
    ba_next    = ba_reg;
    zdone_next = 1'b0;
    rx_in      = '0;
    rx_out     = '0;
    r0z        = 1'b0;
    done_c     = zdone_reg;
    conflict   = 1'b0;
    case (state_reg)
      IDLE: begin
        conflict = g_multi;
        if (g_any) begin
          if (bus.Rin) rx_in = dec;
          if (bus.Rout | bus.BAout) begin
            if (bus.BAout && direct_field == '0) r0z = 1'b1;
            else                                 rx_out = dec;
          end
        end
        if (bus.start) begin
          if (bus.seq_mask != 3'b000) begin
            mask_next  = bus.seq_mask;
            dir_next   = bus.seq_dir;
            ba_next    = bus.seq_ba;
            state_next = ISSUE;
          end else begin
            zdone_next = 1'b1;
          end
        end
      end
      ISSUE: begin
        // Direct strobes and re-starts are ignored here but still flagged.
        conflict = bus.start | g_any;
        if (dir_reg)                           rx_in  = dec;
        else if (ba_reg && seq_field == '0)    r0z    = 1'b1;
        else                                   rx_out = dec;
        mask_next = mask_reg & (mask_reg - 3'd1);
        if (mask_next == 3'b000) begin
          done_c     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    err_next = conflict | (err_reg & ~bus.err_clr);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_reg <= IDLE;
      ir_reg    <= '0;
      mask_reg  <= 3'b000;
      dir_reg   <= 1'b0;
      ba_reg    <= 1'b0;
      zdone_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      mask_reg  <= mask_next;
      dir_reg   <= dir_next;
      ba_reg    <= ba_next;
      zdone_reg <= zdone_next;
      err_reg   <= err_next;
      if (bus.IRin) ir_reg <= bus.IR_Data;
    end
  end

  assign bus.RXin            = rx_in;
  assign bus.RXout           = rx_out;
  assign bus.r0_zero         = r0z;
  assign bus.busy            = (state_reg == ISSUE);
  assign bus.done            = done_c;
  assign bus.err             = err_reg;
  assign bus.C_sign_extended = {{(DATA_WIDTH - C_WIDTH){ir_reg[C_WIDTH-1]}}, ir_reg[C_WIDTH-1:0]};
endmodule

// File: tb/tb_select_encode_seq.sv
// Scoreboard bench for select_encode_seq: stimulus queues hand-computed expectations
// per cycle, an independent monitor compares them on the falling clock edge.
module tb_select_encode_seq;
  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  select_encode_seq_if #(.REG_COUNT(16), .DATA_WIDTH(32)) b0 ();
  select_encode_seq_if #(.REG_COUNT(32), .DATA_WIDTH(32)) b1 ();

  select_encode_seq #(.REG_COUNT(16), .DATA_WIDTH(32), .OPCODE_WIDTH(5), .C_WIDTH(19))
    dut0 (.clock(clock), .clear(clear), .bus(b0.slave));
  select_encode_seq #(.REG_COUNT(32), .DATA_WIDTH(32), .OPCODE_WIDTH(5), .C_WIDTH(19))
    dut1 (.clock(clock), .clear(clear), .bus(b1.slave));

  typedef struct {
    int          cyc;
    int          dut;
    string       name;
    logic [31:0] rxin;
    logic [31:0] rxout;
    logic [31:0] csext;
    logic        r0z;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic [31:0] cs0 = 32'h0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: pop every expectation due this cycle and compare against the DUT.
  always @(negedge clock) begin : monitor
    exp_t        e;
    logic [31:0] a_rxin, a_rxout, a_cs;
    logic        a_r0z, a_busy, a_done, a_err;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      if (e.dut == 0) begin
        a_rxin = 32'(b0.RXin);  a_rxout = 32'(b0.RXout); a_cs = b0.C_sign_extended;
        a_r0z = b0.r0_zero;     a_busy = b0.busy;        a_done = b0.done; a_err = b0.err;
      end else begin
        a_rxin = b1.RXin;       a_rxout = b1.RXout;      a_cs = b1.C_sign_extended;
        a_r0z = b1.r0_zero;     a_busy = b1.busy;        a_done = b1.done; a_err = b1.err;
      end
      chk_cnt++;
      if (e.cyc == cyc && a_rxin === e.rxin && a_rxout === e.rxout && a_cs === e.csext &&
          a_r0z === e.r0z && a_busy === e.busy && a_done === e.done && a_err === e.err) begin
        pass_cnt++;
        $display("check %s: ok (rxin=%h rxout=%h csext=%h r0z=%b busy=%b done=%b err=%b)",
                 e.name, a_rxin, a_rxout, a_cs, a_r0z, a_busy, a_done, a_err);
      end else begin
        $display("FAIL %s cyc=%0d/%0d: got rxin=%h rxout=%h csext=%h r0z=%b busy=%b done=%b err=%b, want rxin=%h rxout=%h csext=%h r0z=%b busy=%b done=%b err=%b",
                 e.name, cyc, e.cyc, a_rxin, a_rxout, a_cs, a_r0z, a_busy, a_done, a_err,
                 e.rxin, e.rxout, e.csext, e.r0z, e.busy, e.done, e.err);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int d, input string name, input logic [31:0] rxin,
                      input logic [31:0] rxout, input logic [31:0] cs, input logic r0z,
                      input logic busy, input logic done, input logic err);
    exp_t e;
    e.cyc = cyc; e.dut = d; e.name = name; e.rxin = rxin; e.rxout = rxout; e.csext = cs;
    e.r0z = r0z; e.busy = busy; e.done = done; e.err = err;
    sb_q.push_back(e);
  endtask

  task automatic exp0(input string name, input logic [31:0] rxin, input logic [31:0] rxout,
                      input logic r0z, input logic busy, input logic done, input logic err);
    push(0, name, rxin, rxout, cs0, r0z, busy, done, err);
  endtask

  task automatic idle0();
    b0.IRin = 0; b0.Gra = 0; b0.Grb = 0; b0.Grc = 0; b0.Rin = 0; b0.Rout = 0;
    b0.BAout = 0; b0.start = 0; b0.err_clr = 0;
  endtask

  task automatic seq0(input logic [2:0] mask, input logic dir, input logic ba);
    b0.start = 1; b0.seq_mask = mask; b0.seq_dir = dir; b0.seq_ba = ba;
  endtask

  initial begin
    idle0(); b0.IR_Data = '0; b0.seq_mask = '0; b0.seq_dir = 0; b0.seq_ba = 0;
    b1.IRin = 0; b1.IR_Data = '0; b1.Gra = 0; b1.Grb = 0; b1.Grc = 0; b1.Rin = 0;
    b1.Rout = 0; b1.BAout = 0; b1.start = 0; b1.seq_mask = '0; b1.seq_dir = 0;
    b1.seq_ba = 0; b1.err_clr = 0;
    step();
    exp0("reset", 0, 0, 0, 0, 0, 0); step();

    clear = 1; b0.IRin = 1; b0.IR_Data = 32'h029E0000; step();
    b0.IRin = 0; cs0 = 32'hFFFE0000;
    exp0("ir_load", 0, 0, 0, 0, 0, 0); step();
    b0.Grb = 1; b0.Rout = 1; exp0("grb_rout", 0, 32'h0008, 0, 0, 0, 0); step();
    idle0(); b0.Grc = 1; b0.Rin = 1; exp0("grc_rin", 32'h1000, 0, 0, 0, 0, 0); step();

    idle0(); seq0(3'b111, 0, 0); exp0("seq_start", 0, 0, 0, 0, 0, 0); step();
    b0.start = 0; exp0("seq_a", 0, 32'h0020, 0, 1, 0, 0); step();
    exp0("seq_b", 0, 32'h0008, 0, 1, 0, 0); step();
    exp0("seq_c", 0, 32'h1000, 0, 1, 1, 0); step();
    exp0("seq_end", 0, 0, 0, 0, 0, 0); step();

    b0.IRin = 1; b0.IR_Data = 32'h02800000; step();
    b0.IRin = 0; cs0 = 32'h0;
    b0.Grb = 1; b0.BAout = 1; exp0("ba_r0", 0, 0, 1, 0, 0, 0); step();
    b0.BAout = 0; b0.Rout = 1; exp0("rout_r0", 0, 32'h0001, 0, 0, 0, 0); step();
    idle0(); b0.Gra = 1; b0.BAout = 1; exp0("ba_nonzero", 0, 32'h0020, 0, 0, 0, 0); step();

    idle0(); seq0(3'b011, 0, 1); exp0("seqba_start", 0, 0, 0, 0, 0, 0); step();
    b0.start = 0; exp0("seqba_a", 0, 32'h0020, 0, 1, 0, 0); step();
    exp0("seqba_b", 0, 0, 1, 1, 1, 0); step();
    exp0("seqba_end", 0, 0, 0, 0, 0, 0); step();

    b0.IRin = 1; b0.IR_Data = 32'h029E0000; step();
    b0.IRin = 0; cs0 = 32'hFFFE0000;
    seq0(3'b111, 1, 0); exp0("seqin_start", 0, 0, 0, 0, 0, 0); step();
    exp0("seqin_a_restart", 32'h0020, 0, 0, 1, 0, 0); step();
    b0.start = 0; b0.Gra = 1; exp0("seqin_b_gra", 32'h0008, 0, 0, 1, 0, 1); step();
    b0.Gra = 0; exp0("seqin_c", 32'h1000, 0, 0, 1, 1, 1); step();
    exp0("err_held", 0, 0, 0, 0, 0, 1); step();
    b0.err_clr = 1; exp0("err_clr_cycle", 0, 0, 0, 0, 0, 1); step();
    b0.err_clr = 0; exp0("err_cleared", 0, 0, 0, 0, 0, 0); step();

    b0.Gra = 1; b0.Grb = 1; b0.Rin = 1; exp0("multi_g", 32'h0080, 0, 0, 0, 0, 0); step();
    idle0(); exp0("multi_err", 0, 0, 0, 0, 0, 1); step();
    b0.err_clr = 1; b0.Gra = 1; b0.Grb = 1; exp0("clr_and_conflict", 0, 0, 0, 0, 0, 1); step();
    b0.Gra = 0; b0.Grb = 0; exp0("clr_after_conflict", 0, 0, 0, 0, 0, 1); step();
    b0.err_clr = 0; exp0("err_cleared2", 0, 0, 0, 0, 0, 0); step();

    seq0(3'b001, 0, 0); exp0("single_start", 0, 0, 0, 0, 0, 0); step();
    b0.start = 0; b0.Gra = 1; exp0("seq_gra_ignored", 0, 32'h0020, 0, 1, 1, 0); step();
    b0.Gra = 0; exp0("gra_err", 0, 0, 0, 0, 0, 1); step();
    b0.err_clr = 1; step();
    b0.err_clr = 0; exp0("err_cleared3", 0, 0, 0, 0, 0, 0); step();

    seq0(3'b000, 0, 0); exp0("zero_start", 0, 0, 0, 0, 0, 0); step();
    b0.start = 0; exp0("zero_done", 0, 0, 0, 0, 1, 0); step();
    exp0("zero_after", 0, 0, 0, 0, 0, 0); step();

    seq0(3'b111, 0, 0); step();
    b0.start = 0; exp0("abort_a", 0, 32'h0020, 0, 1, 0, 0); step();
    clear = 0; cs0 = 32'h0; exp0("abort", 0, 0, 0, 0, 0, 0); step();
    exp0("abort_hold", 0, 0, 0, 0, 0, 0); step();
    clear = 1; exp0("abort_nodone", 0, 0, 0, 0, 0, 0); step();
    exp0("abort_idle", 0, 0, 0, 0, 0, 0); step();

    b1.IRin = 1; b1.IR_Data = 32'h04400000; step();
    b1.IRin = 0; b1.Gra = 1; b1.Rin = 1;
    push(1, "r32_gra_rin", 32'h00020000, 0, 0, 0, 0, 0, 0); step();
    b1.Gra = 0; b1.Rin = 0;
    step(); step();

    chk_cnt++;
    if (sb_q.size() == 0) pass_cnt++;
    else $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
